// File: rtl/num_syst.sv
`default_nettype none
// ============================================================================
// Module   : num_syst
// Purpose  : Number entry from slide switches (KEY1 loads, KEY0 clears) with
//            binary-to-decimal conversion onto three active-low 7-segment
//            digits plus a sign digit.
// Options  : NUM_SYST_SIGNED_EN - show value as two's complement with a
//            minus sign on hex3; undefined gives unsigned 0..255 display.
// Revision : 1.0 - initial release
// ============================================================================
module num_syst #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic [7:0] switches,
    output logic [7:0] value,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_MINUS = 7'b0111111;

    logic [SYNC_STAGES-1:0] r_sync0;
    logic [SYNC_STAGES-1:0] r_sync1;
    logic                   r_hist0;
    logic                   r_hist1;
    logic [7:0]             r_value;

    logic                   w_clr_pulse;
    logic                   w_ld_pulse;
    logic [7:0]             w_mag;
    logic [19:0]            w_dd;
    logic [3:0]             w_hund;
    logic [3:0]             w_tens;
    logic [3:0]             w_ones;

    // Key synchronizers and edge history; reset to the released (high) level
    // so that reset never manufactures a press event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= '1;
            r_sync1 <= '1;
            r_hist0 <= 1'b1;
            r_hist1 <= 1'b1;
        end else begin
            r_sync0 <= {r_sync0[SYNC_STAGES-2:0], KEY0};
            r_sync1 <= {r_sync1[SYNC_STAGES-2:0], KEY1};
            r_hist0 <= r_sync0[SYNC_STAGES-1];
            r_hist1 <= r_sync1[SYNC_STAGES-1];
        end
    end

    // Falling edge of the synchronized key level gives one pulse per press.
    assign w_clr_pulse = r_hist0 & ~r_sync0[SYNC_STAGES-1];
    assign w_ld_pulse  = r_hist1 & ~r_sync1[SYNC_STAGES-1];

    // Captured value register; clear has priority over load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= 8'h00;
        end else if (w_clr_pulse) begin
            r_value <= 8'h00;
        end else if (w_ld_pulse) begin
            r_value <= switches;
        end
    end

    assign value = r_value;

`ifdef NUM_SYST_SIGNED_EN
    // Magnitude of the two's complement value; 0x80 maps to 128.
    assign w_mag = r_value[7] ? (~r_value + 8'd1) : r_value;
    assign hex3  = r_value[7] ? c_SEG_MINUS : c_SEG_BLANK;
`else
    assign w_mag = r_value;
    assign hex3  = c_SEG_BLANK;
`endif

    // Double-dabble: 8 shift steps, add 3 to any BCD nibble >= 5 before each.
    always_comb begin
        w_dd = {12'd0, w_mag};
        for (int i = 0; i < 8; i++) begin
            if (w_dd[11:8]  >= 4'd5) w_dd[11:8]  = w_dd[11:8]  + 4'd3;
            if (w_dd[15:12] >= 4'd5) w_dd[15:12] = w_dd[15:12] + 4'd3;
            if (w_dd[19:16] >= 4'd5) w_dd[19:16] = w_dd[19:16] + 4'd3;
            w_dd = {w_dd[18:0], 1'b0};
        end
    end

    assign w_hund = w_dd[19:16];
    assign w_tens = w_dd[15:12];
    assign w_ones = w_dd[11:8];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = c_SEG_BLANK;
        endcase
    endfunction

    // Leading-zero blanking; the ones digit is always lit.
    assign hex0 = seg7(w_ones);
    assign hex1 = ((w_hund == 4'd0) && (w_tens == 4'd0)) ? c_SEG_BLANK : seg7(w_tens);
    assign hex2 = (w_hund == 4'd0) ? c_SEG_BLANK : seg7(w_hund);

endmodule
`default_nettype wire

// File: tb/tb_num_syst.sv
`default_nettype none
// ============================================================================
// Module   : tb_num_syst
// Purpose  : Directed self-checking bench for num_syst (key conditioning,
//            load/clear, decimal display with blanking, optional sign).
// Revision : 1.0 - initial release
// ============================================================================
module tb_num_syst;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SM = 7'b0111111;

    logic       clk;
    logic       rst;
    logic       KEY0;
    logic       KEY1;
    logic [7:0] switches;
    logic [7:0] value;
    logic [6:0] hex0, hex1, hex2, hex3;

    int checks;
    int errors;

    logic [35:0] got;
    logic [35:0] exp;

    num_syst #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .KEY0     (KEY0),
        .KEY1     (KEY1),
        .switches (switches),
        .value    (value),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive KEY1 low for exactly one rising edge, then wait for the load.
    task automatic press_load(input logic [7:0] sw);
        @(negedge clk);
        switches = sw;
        KEY1 = 1'b0;
        @(negedge clk);
        KEY1 = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; KEY0 = 1'b1; KEY1 = 1'b1; switches = 8'h00;
        repeat (2) @(negedge clk);
        got = {value, hex3, hex2, hex1, hex0};
        exp = {8'h00, SB, SB, SB, S0};
        checks++;
        if (got !== exp) begin
            $display("FAIL reset_state: got %h expected %h", got, exp);
            errors++;
        end
        rst = 1'b0;
        @(negedge clk);
        KEY0 = 1'b0;
        @(negedge clk);
        KEY0 = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (value !== 8'h00) begin
            $display("FAIL clear_after_reset: value %h expected 00", value);
            errors++;
        end
    endtask

    task automatic test_load_20;
        @(negedge clk);
        switches = 8'h20;
        KEY1 = 1'b0;
        @(negedge clk);          // first rising edge sampled KEY1 low
        KEY1 = 1'b1;
        @(negedge clk);          // after 2nd edge: not yet loaded
        checks++;
        if (value !== 8'h00) begin
            $display("FAIL load_latency_early: value %h expected 00", value);
            errors++;
        end
        @(negedge clk);          // after 3rd edge: loaded
        got = {value, hex3, hex2, hex1, hex0};
        exp = {8'h20, SB, SB, S3, S2};
        checks++;
        if (got !== exp) begin
            $display("FAIL load_20: got %h expected %h", got, exp);
            errors++;
        end
    endtask

    task automatic test_sequence;
        press_load(8'h11);
        got = {value, hex3, hex2, hex1, hex0};
        exp = {8'h11, SB, SB, S1, S7};
        checks++;
        if (got !== exp) begin
            $display("FAIL load_11: got %h expected %h", got, exp);
            errors++;
        end
        switches = 8'h20;
        repeat (6) @(negedge clk);
        got = {value, hex3, hex2, hex1, hex0};
        checks++;
        if (got !== exp) begin
            $display("FAIL switch_no_press: got %h expected %h", got, exp);
            errors++;
        end
        press_load(8'h1f);
        got = {value, hex3, hex2, hex1, hex0};
        exp = {8'h1f, SB, SB, S3, S1};
        checks++;
        if (got !== exp) begin
            $display("FAIL load_1f: got %h expected %h", got, exp);
            errors++;
        end
    endtask

    task automatic test_load_80;
        press_load(8'h80);
        got = {value, hex3, hex2, hex1, hex0};
`ifdef NUM_SYST_SIGNED_EN
        exp = {8'h80, SM, S1, S2, S8};
`else
        exp = {8'h80, SB, S1, S2, S8};
`endif
        checks++;
        if (got !== exp) begin
            $display("FAIL load_80: got %h expected %h", got, exp);
            errors++;
        end
    endtask

    task automatic test_ff_0f;
        press_load(8'hff);
        got = {value, hex3, hex2, hex1, hex0};
`ifdef NUM_SYST_SIGNED_EN
        exp = {8'hff, SM, SB, SB, S1};
`else
        exp = {8'hff, SB, S2, S5, S5};
`endif
        checks++;
        if (got !== exp) begin
            $display("FAIL load_ff: got %h expected %h", got, exp);
            errors++;
        end
        press_load(8'h0f);
        got = {value, hex3, hex2, hex1, hex0};
        exp = {8'h0f, SB, SB, S1, S5};
        checks++;
        if (got !== exp) begin
            $display("FAIL load_0f: got %h expected %h", got, exp);
            errors++;
        end
    endtask

    task automatic test_simultaneous;
        @(negedge clk);
        switches = 8'h55;
        KEY0 = 1'b0;
        KEY1 = 1'b0;
        @(negedge clk);
        KEY0 = 1'b1;
        KEY1 = 1'b1;
        repeat (4) @(negedge clk);
        got = {value, hex3, hex2, hex1, hex0};
        exp = {8'h00, SB, SB, SB, S0};
        checks++;
        if (got !== exp) begin
            $display("FAIL clear_wins: got %h expected %h", got, exp);
            errors++;
        end
    endtask

    task automatic test_held_key;
        @(negedge clk);
        switches = 8'h33;
        KEY1 = 1'b0;
        repeat (5) @(negedge clk);
        switches = 8'h44;        // a repeated load would pick this up
        repeat (15) @(negedge clk);
        got = {value, hex3, hex2, hex1, hex0};
        exp = {8'h33, SB, SB, S5, S1};
        checks++;
        if (got !== exp) begin
            $display("FAIL held_during: got %h expected %h", got, exp);
            errors++;
        end
        KEY1 = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (value !== 8'h33) begin
            $display("FAIL held_after_release: value %h expected 33", value);
            errors++;
        end
    endtask

    task automatic test_reset_mid_press;
        @(negedge clk);
        switches = 8'h77;
        KEY1 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (value !== 8'h00) begin
            $display("FAIL async_reset: value %h expected 00", value);
            errors++;
        end
        repeat (2) @(negedge clk);
        KEY1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        got = {value, hex3, hex2, hex1, hex0};
        exp = {8'h00, SB, SB, SB, S0};
        checks++;
        if (got !== exp) begin
            $display("FAIL no_spurious_load: got %h expected %h", got, exp);
            errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_20();
        test_sequence();
        test_load_80();
        test_ff_0f();
        test_simultaneous();
        test_held_key();
        test_reset_mid_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
